// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if -- writeback bus between the two result producers
// (ALU, load unit) and the register-file write port.
//   alu_valid/alu_ready/alu_rd/alu_data : ALU writeback request handshake
//   lsu_valid/lsu_ready/lsu_rd/lsu_data : load-unit writeback request handshake
//   rf_regWrite/rf_writereg/rf_writedata: registered register-file write port
//   wb_count                            : committed non-x0 write counter
// slave modport is the arbiter side, master modport is the requester/consumer side.
interface regfile_wb_arbiter_if #(
  parameter int XLEN = 32
);
  logic            alu_valid;
  logic            alu_ready;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            lsu_valid;
  logic            lsu_ready;
  logic [4:0]      lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            rf_regWrite;
  logic [4:0]      rf_writereg;
  logic [XLEN-1:0] rf_writedata;
  logic [15:0]     wb_count;

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    output alu_ready, lsu_ready,
    output rf_regWrite, rf_writereg, rf_writedata, wb_count
  );

  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    input  alu_ready, lsu_ready,
    input  rf_regWrite, rf_writereg, rf_writedata, wb_count
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter -- arbitrates the ALU and load-unit writeback requests
// onto the single register-file write port, one write per cycle.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : regfile_wb_arbiter_if.slave (request handshakes + write port)
// Parameters: XLEN (data width), MAX_WAIT (ALU starvation bound, 1..15).
// Configuration macro RF_ARB_RR_EN:
//   defined   -> round-robin on contention (MAX_WAIT unused)
//   undefined -> LSU has priority; ALU forced through after MAX_WAIT denials
module regfile_wb_arbiter #(
  parameter int XLEN     = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_wb_arbiter_if.slave  bus
);

  typedef enum logic {LAST_ALU, LAST_LSU} arb_state_e;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  arb_state_e      state_q, state_d;
  logic [3:0]      wait_q, wait_d;
  logic            alu_gnt, lsu_gnt, alu_wins, accept, do_write;
  wb_req_t         win;

  logic            regwrite_q;
  logic [4:0]      writereg_q;
  logic [XLEN-1:0] writedata_q;
  logic [15:0]     count_q;

  // Grant/next-state logic. Readys are forced low while in reset so nothing
  // can be accepted until rst_n releases.
  always_comb begin
    alu_gnt  = 1'b0;
    lsu_gnt  = 1'b0;
    state_d  = state_q;
    wait_d   = wait_q;
`ifdef RF_ARB_RR_EN
    // Favour whichever source did not win last; reset state LAST_LSU makes
    // the first contention go to the ALU.
    alu_wins = (state_q == LAST_LSU);
`else
    // LSU wins unless the ALU has been starved for MAX_WAIT cycles.
    alu_wins = (wait_q == MAX_WAIT_C);
`endif
    if (rst_n) begin
      if (bus.alu_valid && bus.lsu_valid) begin
        alu_gnt = alu_wins;
        lsu_gnt = !alu_wins;
      end else begin
        alu_gnt = bus.alu_valid;
        lsu_gnt = bus.lsu_valid;
      end
    end
    if (alu_gnt)      state_d = LAST_ALU;
    else if (lsu_gnt) state_d = LAST_LSU;
`ifndef RF_ARB_RR_EN
    // Counts only consecutive denied ALU cycles; cannot pass MAX_WAIT since
    // reaching it forces the grant.
    if (alu_gnt || !bus.alu_valid) wait_d = 4'd0;
    else                           wait_d = wait_q + 4'd1;
`endif
  end

  assign accept   = alu_gnt | lsu_gnt;
  assign win      = alu_gnt ? wb_req_t'{bus.alu_rd, bus.alu_data}
                            : wb_req_t'{bus.lsu_rd, bus.lsu_data};
  // x0 writes are accepted (consumed) but never committed.
  assign do_write = accept && (win.rd != 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LAST_LSU;
      wait_q      <= 4'd0;
      regwrite_q  <= 1'b0;
      writereg_q  <= 5'd0;
      writedata_q <= '0;
      count_q     <= 16'd0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      regwrite_q <= do_write;
      if (accept) begin
        writereg_q  <= win.rd;
        writedata_q <= win.data;
      end
      if (do_write) count_q <= count_q + 16'd1;
    end
  end

  assign bus.alu_ready    = alu_gnt;
  assign bus.lsu_ready    = lsu_gnt;
  assign bus.rf_regWrite  = regwrite_q;
  assign bus.rf_writereg  = writereg_q;
  assign bus.rf_writedata = writedata_q;
  assign bus.wb_count     = count_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter -- randomized scoreboard bench for regfile_wb_arbiter.
// The stimulus process holds requests until the reference model grants them,
// queueing the expected readys and expected write-port contents; a negedge
// monitor pops and compares them.
module tb_regfile_wb_arbiter;
  localparam int XLEN     = 32;
  localparam int MAX_WAIT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.XLEN(XLEN)) bus();

  regfile_wb_arbiter #(.XLEN(XLEN), .MAX_WAIT(MAX_WAIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {int cyc; bit a; bit l;} gnt_t;
  typedef struct {int cyc; bit we; logic [4:0] rd; logic [XLEN-1:0] data; logic [15:0] cnt;} wb_t;

  gnt_t gq[$];
  wb_t  wq[$];
  bit   glog[$];   // actual grants seen, 1 = ALU
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  // reference model state
  bit              m_last_alu;
  int              m_wait;
  logic [15:0]     m_cnt;
  bit              a_p, l_p;
  logic [4:0]      a_rd, l_rd;
  logic [XLEN-1:0] a_d, l_d;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_last_alu = 1'b0;
    m_wait     = 0;
    m_cnt      = 16'd0;
    a_p = 1'b0;
    l_p = 1'b0;
    gq.delete();
    wq.delete();
    glog.delete();
  endtask

  // One clock cycle: drive pending requests, predict the grant and the
  // next-cycle write port.
  task automatic step();
    bit ga, gl, acc, we;
    wb_t w;
    @(posedge clk); #1;
    bus.alu_valid = a_p; bus.alu_rd = a_rd; bus.alu_data = a_d;
    bus.lsu_valid = l_p; bus.lsu_rd = l_rd; bus.lsu_data = l_d;
    if (a_p && l_p) begin
`ifdef RF_ARB_RR_EN
      ga = !m_last_alu;
`else
      ga = (m_wait == MAX_WAIT);
`endif
      gl = !ga;
    end else begin
      ga = a_p;
      gl = l_p;
    end
    gq.push_back('{cyc, ga, gl});
    acc = ga || gl;
    w.cyc  = cyc + 1;
    w.rd   = ga ? a_rd : l_rd;
    w.data = ga ? a_d : l_d;
    we     = acc && (w.rd != 5'd0);
    w.we   = we;
    if (we) m_cnt = m_cnt + 16'd1;
    w.cnt  = m_cnt;
    wq.push_back(w);
    if (ga || !a_p) m_wait = 0;
    else            m_wait = m_wait + 1;
    if (ga)      m_last_alu = 1'b1;
    else if (gl) m_last_alu = 1'b0;
    if (ga) a_p = 1'b0;
    if (gl) l_p = 1'b0;
  endtask

  task automatic gen();
    if (!a_p && $urandom_range(0, 99) < 60) begin
      a_p = 1'b1; a_rd = 5'($urandom_range(0, 31)); a_d = $urandom;
    end
    if (!l_p && $urandom_range(0, 99) < 50) begin
      l_p = 1'b1; l_rd = 5'($urandom_range(0, 31)); l_d = $urandom;
    end
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    bus.alu_valid = 1'b0;
    bus.lsu_valid = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    model_reset();
    mon_en = 1'b1;
  endtask

  always @(negedge clk) begin
    gnt_t g;
    wb_t  w;
    if (mon_en) begin
      if (gq.size() > 0 && gq[0].cyc == cyc) begin
        g = gq.pop_front();
        chk("alu_ready", 64'(bus.alu_ready), 64'(g.a));
        chk("lsu_ready", 64'(bus.lsu_ready), 64'(g.l));
        if (bus.alu_ready || bus.lsu_ready) glog.push_back(bus.alu_ready);
      end
      if (wq.size() > 0 && wq[0].cyc == cyc) begin
        w = wq.pop_front();
        chk("rf_regWrite", 64'(bus.rf_regWrite), 64'(w.we));
        if (w.we) begin
          chk("rf_writereg", 64'(bus.rf_writereg), 64'(w.rd));
          chk("rf_writedata", 64'(bus.rf_writedata), 64'(w.data));
        end
        chk("wb_count", 64'(bus.wb_count), 64'(w.cnt));
      end
    end
  end

  initial begin
    bit exp_alu;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = '0;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd4; bus.lsu_data = '0;
    model_reset();
    // reset state, with both requesters asserting valid
    #3;
    chk("rst_regWrite", 64'(bus.rf_regWrite), 64'd0);
    chk("rst_writereg", 64'(bus.rf_writereg), 64'd0);
    chk("rst_writedata", 64'(bus.rf_writedata), 64'd0);
    chk("rst_wb_count", 64'(bus.wb_count), 64'd0);
    chk("rst_alu_ready", 64'(bus.alu_ready), 64'd0);
    chk("rst_lsu_ready", 64'(bus.lsu_ready), 64'd0);
    do_reset();

    // single ALU write rd=5
    a_p = 1'b1; a_rd = 5'd5; a_d = 32'hDEADBEEF;
    step(); step(); step();

    // LSU write to x0: accepted, not committed
    l_p = 1'b1; l_rd = 5'd0; l_d = 32'h1234;
    step(); step(); step();

    // sustained contention from reset, 10 cycles
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (!a_p) begin a_p = 1'b1; a_rd = 5'd1; a_d = $urandom; end
      if (!l_p) begin l_p = 1'b1; l_rd = 5'd2; l_d = $urandom; end
      step();
    end
    a_p = 1'b0; l_p = 1'b0;
    step(); step();
    chk("grant_count", 64'(glog.size()), 64'd10);
    for (int i = 0; i < 10 && i < glog.size(); i++) begin
`ifdef RF_ARB_RR_EN
      exp_alu = (i % 2 == 0);
`else
      exp_alu = (i % 5 == MAX_WAIT);
`endif
      chk($sformatf("grant_seq[%0d]", i), 64'(glog[i]), 64'(exp_alu));
    end

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      gen();
      step();
    end
    a_p = 1'b0; l_p = 1'b0;
    step(); step();

    // reset asserted mid-cycle after an ALU acceptance
    mon_en = 1'b0;
    a_p = 1'b1; a_rd = 5'd7; a_d = 32'hCAFEF00D;
    step();
    #1;
    chk("mid_accept_ready", 64'(bus.alu_ready), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_regWrite", 64'(bus.rf_regWrite), 64'd0);
    chk("mid_rst_wb_count", 64'(bus.wb_count), 64'd0);
    chk("mid_rst_alu_ready", 64'(bus.alu_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      bus.lsu_valid = 1'b1;
      chk("in_rst_regWrite", 64'(bus.rf_regWrite), 64'd0);
      chk("in_rst_alu_ready", 64'(bus.alu_ready), 64'd0);
      chk("in_rst_lsu_ready", 64'(bus.lsu_ready), 64'd0);
    end
    bus.alu_valid = 1'b0;
    bus.lsu_valid = 1'b0;
    #2 rst_n = 1'b1;
    model_reset();
    mon_en = 1'b1;
    step();
    chk("post_rst_regWrite", 64'(bus.rf_regWrite), 64'd0);

    // 65536 committed writes wrap the counter back to zero
    for (int i = 0; i < 65536; i++) begin
      a_p = 1'b1; a_rd = 5'($urandom_range(1, 31)); a_d = $urandom;
      step();
    end
    step(); step();
    chk("wb_count_wrap", 64'(bus.wb_count), 64'd0);

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
